// File: rtl/fw_feeder.sv
// Packs a row-major stream of DW-bit distance elements into 64-bit words and
// feeds them to fw through a small tagged FIFO, honouring fw's inhibit.
module fw_feeder #(
  parameter int DW         = 16,
  parameter int LANES      = 4,
  parameter int N          = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] elem_in,
  input  logic          elem_valid,
  output logic          elem_ready,
  input  logic [1:0]    phase_in,
  input  logic          inhibit,
  output logic [63:0]   outD,
  output logic          out_valid,
  output logic [1:0]    phase,
  output logic          mat_start,
  output logic          mat_done,
  output logic          busy
);

  localparam int WPM = N * N / LANES;
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WW  = (WPM > 1) ? $clog2(WPM) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WPM - 1);

  logic [LW-1:0] r_lane_cnt;
  logic [WW-1:0] r_word_cnt;
  logic [63:0]   r_acc;
  logic [1:0]    r_phase_cur;
  logic          r_ready_en;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [63:0]   r_mem_data [FIFO_DEPTH];
  logic [3:0]    r_mem_tag  [FIFO_DEPTH];
  logic [63:0]   r_out_data;
  logic          r_out_valid;
  logic [1:0]    r_out_phase;
  logic          r_out_start;
  logic          r_out_done;

  logic          w_full;
  logic          w_empty;
  logic          w_last_lane;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_first_elem;
  logic [1:0]    w_phase_word;
  logic [63:0]   w_word;
  logic [3:0]    w_tag;

  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_last_lane  = (r_lane_cnt == LANE_LAST);

  // Handshake: an element transfers on a rising edge where elem_valid && elem_ready.
  // Only the completing lane waits on FIFO space, judged from registered pointers,
  // so a pop on the same edge never frees that slot and inhibit stays off this path.
  assign elem_ready   = r_ready_en && (!w_last_lane || !w_full);
  assign w_accept     = elem_valid && elem_ready;
  assign w_push       = w_accept && w_last_lane;
  assign w_pop        = !inhibit && !w_empty;
  assign w_first_elem = (r_word_cnt == '0) && (r_lane_cnt == '0);
  assign w_phase_word = w_first_elem ? phase_in : r_phase_cur;
  assign w_tag        = {(r_word_cnt == '0), (r_word_cnt == WORD_LAST), w_phase_word};

  always_comb begin
    w_word = r_acc;
    w_word[DW*(LANES-1) +: DW] = elem_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready_en  <= 1'b0;
      r_lane_cnt  <= '0;
      r_word_cnt  <= '0;
      r_acc       <= '0;
      r_phase_cur <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        if (w_first_elem) begin
          r_phase_cur <= phase_in;
        end
        if (w_last_lane) begin
          r_lane_cnt <= '0;
          r_acc      <= '0;
          r_word_cnt <= (r_word_cnt == WORD_LAST) ? '0 : r_word_cnt + 1'b1;
        end else begin
          r_lane_cnt <= r_lane_cnt + 1'b1;
          r_acc[DW*int'(r_lane_cnt) +: DW] <= elem_in;
        end
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr[AW-1:0]] <= w_word;
      r_mem_tag[r_wr_ptr[AW-1:0]]  <= w_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_phase <= '0;
      r_out_start <= 1'b0;
      r_out_done  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_out_data  <= r_mem_data[r_rd_ptr[AW-1:0]];
        r_out_phase <= r_mem_tag[r_rd_ptr[AW-1:0]][1:0];
        r_out_start <= r_mem_tag[r_rd_ptr[AW-1:0]][3];
        r_out_done  <= r_mem_tag[r_rd_ptr[AW-1:0]][2];
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
        r_out_start <= 1'b0;
        r_out_done  <= 1'b0;
      end
    end
  end

  assign outD      = r_out_data;
  assign out_valid = r_out_valid;
  assign phase     = r_out_phase;
  assign mat_start = r_out_start;
  assign mat_done  = r_out_done;
  assign busy      = (r_lane_cnt != '0) || (r_word_cnt != '0) || !w_empty;

endmodule

// File: tb/tb_fw_feeder.sv
// Randomised bench for fw_feeder: a matrix-level packing model feeds an
// expected queue that an independent output monitor drains and compares.
module tb_fw_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] elem_in = '0;
  logic        elem_valid = 1'b0;
  logic        elem_ready;
  logic [1:0]  phase_in = '0;
  logic        inhibit = 1'b0;
  logic [63:0] outD;
  logic        out_valid;
  logic [1:0]  phase;
  logic        mat_start;
  logic        mat_done;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int inh_mode = 0;
  int gap_max = 0;
  int cyc = 0;
  logic inh_d = 1'b0;

  logic [67:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          obs_cyc[$];

  int          m_idx = 0;
  logic [63:0] m_word = '0;
  logic [1:0]  m_phase = '0;

  fw_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .elem_in    (elem_in),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .phase_in   (phase_in),
    .inhibit    (inhibit),
    .outD       (outD),
    .out_valid  (out_valid),
    .phase      (phase),
    .mat_start  (mat_start),
    .mat_done   (mat_done),
    .busy       (busy)
  );

  // clock / reset infrastructure
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference model: element index within the matrix decides lane, word and tags.
  function automatic void model_accept(input logic [15:0] d, input logic [1:0] p);
    int lane = m_idx % 4;
    int widx = m_idx / 4;
    if (m_idx == 0) m_phase = p;
    m_word = m_word | ({48'd0, d} << (16 * lane));
    if (lane == 3) begin
      exp_q.push_back({(widx == 0), (widx == 15), m_phase, m_word});
      m_word = '0;
    end
    m_idx = (m_idx + 1) % 64;
  endfunction

  // inhibit driver: 0 off, 1 held, 2 random 1-in-3, 3 manual
  initial forever begin
    @(posedge clk); #1;
    case (inh_mode)
      0: inhibit = 1'b0;
      1: inhibit = 1'b1;
      2: inhibit = ($urandom_range(0, 2) == 0);
      default: ;
    endcase
  end

  // monitor
  always @(negedge clk) begin
    if (reset) begin
      if (inh_d) check("inhibit_no_word", {67'd0, out_valid}, 68'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {mat_start, mat_done, phase, outD}, 68'd0);
          tests--; if ({mat_start, mat_done, phase, outD} === 68'd0) begin tests++; fails++;
            $display("FAIL unexpected_word: got word with empty queue, required none"); end
          else tests++;
        end else begin
          check("out_word", {mat_start, mat_done, phase, outD}, exp_q.pop_front());
        end
        obs_q.push_back(outD);
        obs_cyc.push_back(cyc);
      end
    end
    inh_d = inhibit;
  end

  task automatic drive_elem(input logic [15:0] d, input logic [1:0] p);
    int waited = 0;
    bit done = 0;
    if (gap_max > 0) begin
      elem_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
    elem_in = d; phase_in = p; elem_valid = 1'b1;
    while (!done && waited < 300) begin
      @(negedge clk);
      if (elem_ready) begin
        model_accept(d, p);
        done = 1;
      end
      @(posedge clk); #1;
      waited++;
    end
    elem_valid = 1'b0;
    if (!done) check("drive_timeout", 68'd0, 68'd1);
  endtask

  task automatic feed_random(input int n, input logic [1:0] p_first);
    for (int i = 0; i < n; i++) begin
      drive_elem(16'($urandom), (m_idx == 0) ? p_first : 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    inh_mode = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", {36'd0, 32'(exp_q.size())}, 68'd0);
  endtask

  task automatic stall_check(input string name, input logic [15:0] d, input int n);
    int seen = 0;
    elem_in = d; elem_valid = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (elem_ready) seen++;
    end
    @(posedge clk); #1;
    check(name, {36'd0, 32'(seen)}, 68'd0);
  endtask

  initial begin
    logic [15:0] t1 [8];
    logic [15:0] d;
    t1 = '{16'h0000, 16'h0054, 16'h0057, 16'h004e, 16'h0010, 16'h005e, 16'h0024, 16'h0057};

    // reset state
    repeat (3) @(posedge clk); #1;
    check("rst_outputs", {mat_start, mat_done, phase, outD}, 68'd0);
    check("rst_flags", {65'd0, out_valid, busy, elem_ready}, 68'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", {67'd0, elem_ready}, 68'd1);

    // directed packing then rest of a matrix, phase 01 on element 0 only
    obs_q.delete(); obs_cyc.delete();
    for (int i = 0; i < 8; i++) drive_elem(t1[i], (i == 0) ? 2'b01 : 2'b10);
    for (int i = 8; i < 64; i++) drive_elem(16'($urandom), 2'b10);
    wait_drain();
    check("t1_word0", (obs_q.size() > 0) ? {4'd0, obs_q[0]} : 68'hbad, {4'd0, 64'h004e_0057_0054_0000});
    check("t1_word1", (obs_q.size() > 1) ? {4'd0, obs_q[1]} : 68'hbad, {4'd0, 64'h0057_0024_005e_0010});
    check("t2_word_count", {36'd0, 32'(obs_q.size())}, 68'd16);
    check("t2_busy_idle", {67'd0, busy}, 68'd0);

    // inhibit held while streaming
    obs_q.delete(); obs_cyc.delete();
    inh_mode = 1; inhibit = 1'b1;
    feed_random(16, 2'b11);
    check("t3_lane0_ready", {67'd0, elem_ready}, 68'd1);
    feed_random(3, 2'b00);
    d = 16'($urandom);
    stall_check("t3_stall_ready", d, 10);
    inh_mode = 0; inhibit = 1'b0;
    drive_elem(d, 2'b00);
    feed_random(44, 2'b00);
    wait_drain();
    for (int i = 0; i < 3; i++) begin
      check("t3_back_to_back",
            (obs_cyc.size() > i + 1) ? {36'd0, 32'(obs_cyc[i+1] - obs_cyc[i])} : 68'hbad, 68'd1);
    end

    // gappy valid and random inhibit across two matrices
    inh_mode = 2; gap_max = 1;
    feed_random(64, 2'($urandom_range(0, 3)));
    feed_random(64, 2'($urandom_range(0, 3)));
    gap_max = 0;
    wait_drain();
    check("t4_busy_idle", {67'd0, busy}, 68'd0);

    // asynchronous reset mid-matrix
    feed_random(6, 2'b10);
    reset = 1'b0;
    #1;
    check("t5_rst_outputs", {mat_start, mat_done, phase, outD}, 68'd0);
    check("t5_rst_flags", {65'd0, out_valid, busy, elem_ready}, 68'd0);
    exp_q.delete(); m_idx = 0; m_word = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    feed_random(64, 2'b11);
    wait_drain();

    // push and pop on the same edge at 3/4 occupancy
    inh_mode = 3; inhibit = 1'b1;
    @(posedge clk); #1;
    feed_random(15, 2'b01);
    inhibit = 1'b0;
    drive_elem(16'($urandom), 2'b00);
    inhibit = 1'b1;
    feed_random(7, 2'b00);
    d = 16'($urandom);
    stall_check("t6_full_stall", d, 5);
    inh_mode = 0; inhibit = 1'b0;
    drive_elem(d, 2'b00);
    feed_random(40, 2'b00);
    wait_drain();
    check("final_busy", {67'd0, busy}, 68'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
